// File: rtl/ahb_lite_master.sv
// ahb_lite_master
//   AHB-Lite initiator for the FIR register-file slave bus. Host requests
//   (valid/ready) become NONSEQ transfers through a two-stage pipeline:
//   stage p0 is the address phase, stage p1 the data phase, and p2 holds the
//   one-cycle response. The address phase of one transfer overlaps the data
//   phase of the previous one, so a held req_valid gives one transfer/cycle.
//
// Ports
//   clk, n_rst              clock (rising edge), async active-low reset
//   req_valid/req_ready     host request handshake (ready = ~err_flag)
//   req_write/addr/size/wdata  request fields (size 0 = byte [7:0])
//   rsp_valid/rdata/err     one-cycle completion pulse with read data/status
//   err_flag, clr_err       sticky slave-error flag and its clear
//   xfer_cnt, err_cnt       saturating completed / errored transfer counters
//   hsel, haddr, htrans, hwrite, hsize, hwdata   bus outputs
//   hrdata, hresp           bus inputs, sampled at the end of the data phase
module ahb_lite_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              err_flag,
  input  logic              clr_err,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic              hsize,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Byte transfers only carry bits [7:0]; the upper lanes are forced to zero.
  function automatic logic [DATA_W-1:0] size_mask(input logic sz,
                                                  input logic [DATA_W-1:0] d);
    size_mask = sz ? d : {{(DATA_W-8){1'b0}}, d[7:0]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              w_accept;
  logic              r_vld_p0;
  logic [ADDR_W-1:0] r_addr_p0;
  logic              r_write_p0;
  logic              r_size_p0;
  logic [DATA_W-1:0] r_wdata_p0;
  logic              r_vld_p1;
  logic              r_write_p1;
  logic              r_size_p1;
  logic [DATA_W-1:0] r_hwdata_p1;
  logic              r_vld_p2;
  logic [DATA_W-1:0] r_rdata_p2;
  logic              r_err_p2;
  logic              r_err_flag;
  logic [CNT_W-1:0]  r_xfer_cnt;
  logic [CNT_W-1:0]  r_err_cnt;

  assign w_accept = req_valid & ~r_err_flag;

  // Stage p0: address phase. The address/control registers load only on
  // acceptance, so haddr/hwrite/hsize hold their last values while idle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_vld_p0   <= 1'b0;
      r_addr_p0  <= '0;
      r_write_p0 <= 1'b0;
      r_size_p0  <= 1'b0;
      r_wdata_p0 <= '0;
    end else begin
      r_vld_p0 <= w_accept;
      if (w_accept) begin
        r_addr_p0  <= req_addr;
        r_write_p0 <= req_write;
        r_size_p0  <= req_size;
        r_wdata_p0 <= req_wdata;
      end
    end
  end

  // Stage p1: data phase. Write data is lane-masked on entry; reads drive 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_vld_p1    <= 1'b0;
      r_write_p1  <= 1'b0;
      r_size_p1   <= 1'b0;
      r_hwdata_p1 <= '0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0) begin
        r_write_p1  <= r_write_p0;
        r_size_p1   <= r_size_p0;
        r_hwdata_p1 <= r_write_p0 ? size_mask(r_size_p0, r_wdata_p0) : '0;
      end
    end
  end

  // Stage p2: response. hrdata/hresp are sampled on the edge leaving p1; an
  // error sets the sticky flag on that same edge and beats a concurrent clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_vld_p2   <= 1'b0;
      r_rdata_p2 <= '0;
      r_err_p2   <= 1'b0;
      r_err_flag <= 1'b0;
      r_xfer_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_rdata_p2 <= r_write_p1 ? '0 : size_mask(r_size_p1, hrdata);
        r_err_p2   <= hresp;
        r_xfer_cnt <= sat_inc(r_xfer_cnt);
        if (hresp) begin
          r_err_cnt <= sat_inc(r_err_cnt);
        end
      end
      if (r_vld_p1 && hresp) begin
        r_err_flag <= 1'b1;
      end else if (clr_err) begin
        r_err_flag <= 1'b0;
      end
    end
  end

  assign req_ready = ~r_err_flag;
  assign htrans    = r_vld_p0 ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsel      = r_vld_p0 | r_vld_p1;
  assign haddr     = r_addr_p0;
  assign hwrite    = r_write_p0;
  assign hsize     = r_size_p0;
  assign hwdata    = r_vld_p1 ? r_hwdata_p1 : '0;
  assign rsp_valid = r_vld_p2;
  assign rsp_rdata = r_rdata_p2;
  assign rsp_err   = r_err_p2;
  assign err_flag  = r_err_flag;
  assign xfer_cnt  = r_xfer_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master
//   Self-checking bench for ahb_lite_master. A transfer-level model tracks the
//   requests accepted on the last three clock edges (address phase, data
//   phase, response) and predicts every bus and host output each cycle. The
//   bench also plays the slave, returning per-transfer read data and hresp
//   chosen when the request is issued.
module tb_ahb_lite_master;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              req_valid, req_ready, req_write, req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_err, err_flag, clr_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [CNT_W-1:0]  xfer_cnt, err_cnt;
  logic              hsel, hwrite, hsize, hresp;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [DATA_W-1:0] hwdata, hrdata;

  always #5 clk = ~clk;

  ahb_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_flag(err_flag), .clr_err(clr_err),
    .xfer_cnt(xfer_cnt), .err_cnt(err_cnt),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp)
  );

  typedef struct {
    bit          v;
    bit          w;
    logic [3:0]  a;
    bit          s;
    logic [15:0] wd;
    logic [15:0] rd;
    bit          e;
  } xfer_t;

  // h0: accepted on the latest edge (address phase now)
  // h1: accepted one edge earlier (data phase now)
  // h2: accepted two edges earlier (response now)
  xfer_t       h0, h1, h2;
  bit          m_err;
  int          m_xfer, m_errc;
  logic [3:0]  m_addr;
  bit          m_write, m_size;
  logic [15:0] slv_rd;
  bit          slv_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic xfer_t none_x();
    xfer_t x;
    x.v = 0; x.w = 0; x.a = '0; x.s = 0; x.wd = '0; x.rd = '0; x.e = 0;
    return x;
  endfunction

  function automatic logic [15:0] bmask(input bit s, input logic [15:0] d);
    return s ? d : {8'h00, d[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    h0 = none_x(); h1 = none_x(); h2 = none_x();
    m_err = 0; m_xfer = 0; m_errc = 0;
    m_addr = '0; m_write = 0; m_size = 0;
  endtask

  // Advance the model across one clock edge using the inputs present before it.
  task automatic model_edge();
    xfer_t n;
    n = none_x();
    if (req_valid && !m_err) begin
      n.v = 1; n.w = req_write; n.a = req_addr; n.s = req_size;
      n.wd = req_wdata; n.rd = slv_rd; n.e = slv_err;
    end
    h2 = h1; h1 = h0; h0 = n;
    if (h2.v) begin
      m_xfer = (m_xfer < 255) ? m_xfer + 1 : 255;
      if (h2.e) m_errc = (m_errc < 255) ? m_errc + 1 : 255;
    end
    if (h2.v && h2.e) m_err = 1;
    else if (clr_err) m_err = 0;
    if (h0.v) begin
      m_addr = h0.a; m_write = h0.w; m_size = h0.s;
    end
  endtask

  task automatic compare();
    chk("req_ready", req_ready, !m_err);
    chk("htrans", htrans, h0.v ? 2'b10 : 2'b00);
    chk("hsel", hsel, h0.v | h1.v);
    chk("haddr", haddr, m_addr);
    chk("hwrite", hwrite, m_write);
    chk("hsize", hsize, m_size);
    if (h1.v) chk("hwdata", hwdata, h1.w ? bmask(h1.s, h1.wd) : 16'h0000);
    chk("rsp_valid", rsp_valid, h2.v);
    if (h2.v) begin
      chk("rsp_err", rsp_err, h2.e);
      chk("rsp_rdata", rsp_rdata, h2.w ? 16'h0000 : bmask(h2.s, h2.rd));
    end
    chk("err_flag", err_flag, m_err);
    chk("xfer_cnt", xfer_cnt, m_xfer);
    chk("err_cnt", err_cnt, m_errc);
  endtask

  // Slave: meaningful data only during a data phase, noise otherwise.
  task automatic drive_slave();
    if (h1.v) begin
      hrdata = h1.rd; hresp = h1.e;
    end else begin
      hrdata = 16'($urandom); hresp = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare();
    drive_slave();
  endtask

  task automatic reset_assert();
    req_valid = 0; clr_err = 0;
    n_rst = 0;
    #1;
    model_clear();
    compare();
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    n_rst = 1;
    drive_slave();
  endtask

  task automatic set_req(input bit w, input logic [3:0] a, input bit s,
                         input logic [15:0] wd, input logic [15:0] rd, input bit e);
    req_valid = 1; req_write = w; req_addr = a; req_size = s;
    req_wdata = wd; slv_rd = rd; slv_err = e;
  endtask

  initial begin
    int nonseq_c, hsel_c, rsp_c, first_rsp, last_rsp;
    n_rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_size = 0;
    req_wdata = '0; clr_err = 0; hrdata = '0; hresp = 0;
    slv_rd = '0; slv_err = 0;
    model_clear();
    #2;
    reset_assert();
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_hsel", hsel, 1'b0);
    chk("rst_hwdata", hwdata, 16'h0000);
    chk("rst_xfer_cnt", xfer_cnt, 8'h00);
    reset_release();

    // Halfword write 0x1234 to 0x4
    set_req(1, 4'h4, 1, 16'h1234, 16'h0000, 0);
    step();
    chk("wr_htrans", htrans, 2'b10);
    chk("wr_haddr", haddr, 4'h4);
    chk("wr_hwrite", hwrite, 1'b1);
    req_valid = 0;
    step();
    chk("wr_hwdata", hwdata, 16'h1234);
    step();
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_err", rsp_err, 1'b0);
    chk("wr_rsp_rdata", rsp_rdata, 16'h0000);
    chk("wr_xfer_cnt", xfer_cnt, 8'h01);

    // Read 0x2, slave returns 0xBEEF
    set_req(0, 4'h2, 1, 16'h0000, 16'hBEEF, 0);
    step();
    req_valid = 0;
    step();
    step();
    chk("rd_rsp_rdata", rsp_rdata, 16'hBEEF);
    chk("rd_rsp_err", rsp_err, 1'b0);

    // Byte write then byte read of 0x6
    set_req(1, 4'h6, 0, 16'hAB55, 16'h0000, 0);
    step();
    req_valid = 0;
    step();
    chk("bw_hwdata", hwdata, 16'h0055);
    step();
    set_req(0, 4'h6, 0, 16'h0000, 16'hAB55, 0);
    step();
    req_valid = 0;
    step();
    step();
    chk("br_rsp_rdata", rsp_rdata, 16'h0055);

    // Four back-to-back reads
    nonseq_c = 0; hsel_c = 0; rsp_c = 0; first_rsp = -1; last_rsp = -1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) set_req(0, 4'(i + 8), 1, 16'h0000, 16'h1000 + 16'(i), 0);
      else req_valid = 0;
      step();
      if (htrans == 2'b10) nonseq_c++;
      if (hsel) hsel_c++;
      if (rsp_valid) begin
        chk("b2b_order", rsp_rdata, 16'h1000 + 16'(rsp_c));
        if (first_rsp < 0) first_rsp = i;
        last_rsp = i;
        rsp_c++;
      end
    end
    chk("b2b_nonseq_cycles", nonseq_c, 4);
    chk("b2b_hsel_cycles", hsel_c, 5);
    chk("b2b_rsp_count", rsp_c, 4);
    chk("b2b_first_rsp", first_rsp, 2);
    chk("b2b_last_rsp", last_rsp, 5);

    // Error on read-only 0x0, then a good write to 0x8
    reset_assert();
    reset_release();
    set_req(1, 4'h0, 1, 16'h5A5A, 16'h0000, 1);
    step();
    set_req(1, 4'h8, 1, 16'h0123, 16'h0000, 0);
    step();
    req_valid = 0;
    step();
    chk("err_rsp_err1", rsp_err, 1'b1);
    chk("err_flag_set", err_flag, 1'b1);
    chk("err_req_ready", req_ready, 1'b0);
    step();
    chk("err_rsp_valid2", rsp_valid, 1'b1);
    chk("err_rsp_err2", rsp_err, 1'b0);
    chk("err_err_cnt", err_cnt, 8'h01);
    chk("err_xfer_cnt", xfer_cnt, 8'h02);
    clr_err = 1;
    step();
    clr_err = 0;
    chk("clr_req_ready", req_ready, 1'b1);
    chk("clr_err_flag", err_flag, 1'b0);

    // Async reset during the data phase of a write
    set_req(1, 4'h3, 1, 16'hC0DE, 16'h0000, 0);
    step();
    req_valid = 0;
    step();
    n_rst = 0;
    #1;
    chk("ar_htrans", htrans, 2'b00);
    chk("ar_hsel", hsel, 1'b0);
    chk("ar_haddr", haddr, 4'h0);
    chk("ar_hwrite", hwrite, 1'b0);
    chk("ar_hsize", hsize, 1'b0);
    chk("ar_hwdata", hwdata, 16'h0000);
    chk("ar_rsp_valid", rsp_valid, 1'b0);
    chk("ar_rsp_rdata", rsp_rdata, 16'h0000);
    chk("ar_rsp_err", rsp_err, 1'b0);
    chk("ar_err_flag", err_flag, 1'b0);
    chk("ar_xfer_cnt", xfer_cnt, 8'h00);
    chk("ar_err_cnt", err_cnt, 8'h00);
    model_clear();
    reset_release();
    step();
    step();
    chk("ar_no_rsp", rsp_valid, 1'b0);
    set_req(1, 4'h5, 1, 16'h0F0F, 16'h0000, 0);
    step();
    chk("ar_new_htrans", htrans, 2'b10);
    req_valid = 0;
    step();
    step();
    chk("ar_new_rsp", rsp_valid, 1'b1);
    chk("ar_new_xfer_cnt", xfer_cnt, 8'h01);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 4'($urandom);
      req_size  = 1'($urandom_range(0, 1));
      req_wdata = 16'($urandom);
      slv_rd    = 16'($urandom);
      slv_err   = ($urandom_range(0, 15) == 0);
      clr_err   = ($urandom_range(0, 3) == 0);
      step();
    end

    // Every transfer errors and clr_err is held: drives both counters to saturation
    for (int i = 0; i < 1200; i++) begin
      req_valid = 1;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 4'($urandom);
      req_size  = 1'($urandom_range(0, 1));
      req_wdata = 16'($urandom);
      slv_rd    = 16'($urandom);
      slv_err   = 1;
      clr_err   = 1;
      step();
    end
    req_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("sat_xfer_cnt", xfer_cnt, 8'hFF);
    chk("sat_err_cnt", err_cnt, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
